// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array data movers.
//   DEF_DATA_WIDTH   : default bits per activation word
//   DEF_STREAM_WIDTH : default activation words per stream beat
//   state_t          : job-sequencer states (IDLE -> LOAD -> RUN -> DONE)
package systolic_pkg;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_STREAM_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry skid buffer between the source-memory read port and the feeder.
//
// Handshake: a beat moves across a valid/ready pair exactly on a cycle where
// valid and ready are both 1.  While valid is 1 and ready is 0 the producer
// holds valid and data unchanged.  The input side carries valid only: the
// producer reserves space itself using count_o (occupancy) and must never
// push into a full buffer.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (empties buffer)
//   in_valid_i      : write a beat this cycle
//   in_data_i       : beat being written
//   out_valid_o     : head entry valid
//   out_ready_i     : consumer accepts the head entry this cycle
//   out_data_o      : head entry (registered, stable while not accepted)
//   count_o         : entries currently held (0..2)
module stream_skid2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [1:0]       count_o
);

   logic             head_valid_q, head_valid_d;
   logic             spare_valid_q, spare_valid_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] spare_q, spare_d;
   logic             pop;

   assign pop = head_valid_q & out_ready_i;

   always_comb begin
      head_valid_d  = head_valid_q;
      head_d        = head_q;
      spare_valid_d = spare_valid_q;
      spare_d       = spare_q;
      if (pop) begin
         if (spare_valid_q) begin
            // Spare moves up to the head; an incoming beat refills the spare.
            head_d        = spare_q;
            spare_valid_d = in_valid_i;
            if (in_valid_i) begin
               spare_d = in_data_i;
            end
         end else begin
            head_valid_d = in_valid_i;
            if (in_valid_i) begin
               head_d = in_data_i;
            end
         end
      end else if (in_valid_i) begin
         if (!head_valid_q) begin
            head_valid_d = 1'b1;
            head_d       = in_data_i;
         end else begin
            spare_valid_d = 1'b1;
            spare_d       = in_data_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_valid_q  <= 1'b0;
         spare_valid_q <= 1'b0;
         head_q        <= '0;
         spare_q       <= '0;
      end else begin
         head_valid_q  <= head_valid_d;
         spare_valid_q <= spare_valid_d;
         head_q        <= head_d;
         spare_q       <= spare_d;
      end
   end

   assign out_valid_o = head_valid_q;
   assign out_data_o  = head_q;
   assign count_o     = {1'b0, head_valid_q} + {1'b0, spare_valid_q};

endmodule

// File: rtl/ifmap_streamer.sv
// Input-feature-map streamer: reads in_cols*in_cols*chans_per_mem*batch beats
// from source memory at addresses 0..total-1 and streams them, lane-reversed,
// to the systolic feeder through a two-entry skid buffer.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle job launch (only honoured in IDLE)
//   cfg_in_cols         : input rows = columns
//   cfg_chans_per_mem   : beats per pixel
//   cfg_batch           : batch size
//   mem_rd_en, mem_addr : source read strobe / address
//   mem_rdata           : read data, valid the cycle after mem_rd_en
//   data_in, valid_write: beat to the feeder and its valid
//   ram_full            : feeder backpressure (ready = ~ram_full)
//   feed_start          : level, high from first valid_write until DONE
//   busy                : job in progress (LOAD, RUN, DONE)
//   done                : one-cycle job-complete pulse
//   cfg_err             : sticky oversize-job flag, cleared by next start
//   dbg_state_o         : current sequencer state
module ifmap_streamer
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int STREAM_WIDTH = DEF_STREAM_WIDTH,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [ADDR_WIDTH-1:0]              cfg_in_cols,
   input  logic [ADDR_WIDTH-1:0]              cfg_chans_per_mem,
   input  logic [ADDR_WIDTH-1:0]              cfg_batch,
   output logic                               mem_rd_en,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   input  logic [DATA_WIDTH*STREAM_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH*STREAM_WIDTH-1:0] data_in,
   output logic                               valid_write,
   input  logic                               ram_full,
   output logic                               feed_start,
   output logic                               busy,
   output logic                               done,
   output logic                               cfg_err,
   output logic [1:0]                         dbg_state_o
);

   localparam int          BW        = DATA_WIDTH * STREAM_WIDTH;
   localparam int          CW        = ADDR_WIDTH + 1;  // counts up to 2**ADDR_WIDTH
   localparam logic [32:0] MAX_BEATS = 33'(1) << ADDR_WIDTH;

   state_t          state_q, state_d;
   logic [31:0]     total_q, total_d;
   logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]   xfer_cnt_q, xfer_cnt_d;
   logic            inflight_q;
   logic            feed_q, feed_d;
   logic            cfg_err_q, cfg_err_d;
   logic [BW-1:0]   rdata_rev;
   logic [1:0]      skid_count;
   logic [1:0]      level;
   logic            xfer;
   logic            room;

   // Memory lane STREAM_WIDTH-1-u lands on feeder lane u.
   for (genvar u = 0; u < STREAM_WIDTH; u++) begin : g_lane
      assign rdata_rev[u*DATA_WIDTH +: DATA_WIDTH] =
         mem_rdata[(STREAM_WIDTH-1-u)*DATA_WIDTH +: DATA_WIDTH];
   end

   // Only a read that was actually issued pushes; reset clears inflight_q,
   // so a read outstanding at reset is never captured.
   stream_skid2 #(.WIDTH(BW)) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (inflight_q),
      .in_data_i   (rdata_rev),
      .out_valid_o (valid_write),
      .out_ready_i (~ram_full),
      .out_data_o  (data_in),
      .count_o     (skid_count)
   );

   assign xfer  = valid_write & ~ram_full;
   assign level = skid_count + {1'b0, inflight_q};
   // Credit check: held beats plus reads in flight, less the beat leaving this
   // cycle, must stay below 2.  Counting the departing beat is what sustains
   // one read per cycle in steady state.
   assign room      = (level < 2'd2) || (xfer && (level == 2'd2));
   assign mem_rd_en = (state_q == RUN) && (rd_cnt_q < CW'(total_q)) && room;
   assign mem_addr  = rd_cnt_q[ADDR_WIDTH-1:0];

   always_comb begin
      state_d    = state_q;
      total_d    = total_q;
      rd_cnt_d   = rd_cnt_q;
      xfer_cnt_d = xfer_cnt_q;
      cfg_err_d  = cfg_err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               total_d    = 32'(cfg_in_cols) * 32'(cfg_in_cols) *
                            32'(cfg_chans_per_mem) * 32'(cfg_batch);
               rd_cnt_d   = '0;
               xfer_cnt_d = '0;
               cfg_err_d  = 1'b0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            if ({1'b0, total_q} > MAX_BEATS) begin
               cfg_err_d = 1'b1;
               state_d   = IDLE;
            end else if (total_q == 32'd0) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (mem_rd_en) begin
               rd_cnt_d = rd_cnt_q + CW'(1);
            end
            if (xfer) begin
               xfer_cnt_d = xfer_cnt_q + CW'(1);
               if (xfer_cnt_q == CW'(total_q) - CW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // feed_q remembers that the stream has begun; gated by RUN on the output
   // so feed_start drops as soon as DONE is entered.
   assign feed_d = (state_q == RUN) && (feed_q || valid_write);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         total_q    <= '0;
         rd_cnt_q   <= '0;
         xfer_cnt_q <= '0;
         inflight_q <= 1'b0;
         feed_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         rd_cnt_q   <= rd_cnt_d;
         xfer_cnt_q <= xfer_cnt_d;
         inflight_q <= mem_rd_en;
         feed_q     <= feed_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign feed_start  = (state_q == RUN) && (feed_q || valid_write);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign cfg_err     = cfg_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifmap_streamer.sv
// Directed bench for ifmap_streamer with a scoreboard fed from the read side
// and drained on every feeder transfer.
module tb_ifmap_streamer;
   import systolic_pkg::*;

   localparam int DW = 8;
   localparam int SW = 4;
   localparam int AW = 16;
   localparam int BW = DW * SW;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] cfg_in_cols, cfg_chans_per_mem, cfg_batch;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_rdata = '1;
   logic [BW-1:0] data_in;
   logic          valid_write, ram_full, feed_start, busy, done, cfg_err;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   ifmap_streamer #(.DATA_WIDTH(DW), .STREAM_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .cfg_in_cols       (cfg_in_cols),
      .cfg_chans_per_mem (cfg_chans_per_mem),
      .cfg_batch         (cfg_batch),
      .mem_rd_en         (mem_rd_en),
      .mem_addr          (mem_addr),
      .mem_rdata         (mem_rdata),
      .data_in           (data_in),
      .valid_write       (valid_write),
      .ram_full          (ram_full),
      .feed_start        (feed_start),
      .busy              (busy),
      .done              (done),
      .cfg_err           (cfg_err),
      .dbg_state_o       (dbg_state)
   );

   // ---------------- source memory model ----------------
   function automatic logic [BW-1:0] mem_word(input int addr);
      logic [BW-1:0] w;
      for (int k = 0; k < SW; k++) w[k*DW +: DW] = DW'((addr * SW + k) * 37 + 5);
      return w;
   endfunction

   function automatic logic [BW-1:0] reverse_lanes(input logic [BW-1:0] w);
      logic [BW-1:0] r;
      for (int u = 0; u < SW; u++) r[u*DW +: DW] = w[(SW-1-u)*DW +: DW];
      return r;
   endfunction

   // Data is valid exactly one cycle after the strobe; all-ones otherwise.
   always @(posedge clk) mem_rdata <= mem_rd_en ? mem_word(int'(mem_addr)) : '1;

   // ---------------- scoreboard / counters ----------------
   int            chk_cnt = 0;
   int            pass_cnt = 0;
   logic [BW-1:0] exp_q[$];
   int            exp_addr = 0;
   int            rd_total = 0, beat_total = 0, done_total = 0, stall_total = 0;
   logic          fs_flag = 1'b0, stall_prev = 1'b0;
   logic [BW-1:0] stall_data = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic monitor_loop();
      logic [BW-1:0] exp_w;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_addr   = 0;
            fs_flag    = 1'b0;
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("stall_valid_held", 64'(valid_write), 64'(1));
               check("stall_data_held", 64'(data_in), 64'(stall_data));
            end
            if (start && !busy) exp_addr = 0;
            if (mem_rd_en) begin
               check("rd_addr", 64'(mem_addr), 64'(exp_addr));
               exp_q.push_back(reverse_lanes(mem_word(exp_addr)));
               exp_addr++;
               rd_total++;
            end
            if (valid_write && !ram_full) begin
               check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
               if (exp_q.size() > 0) begin
                  exp_w = exp_q.pop_front();
                  check("beat_data", 64'(data_in), 64'(exp_w));
               end
               beat_total++;
            end
            if (valid_write && ram_full) stall_total++;
            if (valid_write) fs_flag = 1'b1;
            check("feed_start", 64'(feed_start), 64'(fs_flag && !done));
            if (done) begin
               done_total++;
               fs_flag = 1'b0;
            end
            stall_prev = valid_write && ram_full;
            stall_data = data_in;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic launch(input int cols, input int chans, input int batch);
      @(posedge clk); #1;
      cfg_in_cols       = AW'(cols);
      cfg_chans_per_mem = AW'(chans);
      cfg_batch         = AW'(batch);
      start             = 1'b1;
      @(posedge clk); #1;  // this edge samples start
      start = 1'b0;
   endtask

   // k counts cycles after the start cycle (k=1 is the cycle after the sampling edge).
   task automatic run_job(input int limit, output int vw_k, output int done_k);
      vw_k   = -1;
      done_k = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (valid_write && vw_k < 0) vw_k = k;
         if (done) begin
            done_k = k;
            break;
         end
      end
      #1;
      check("job_done_seen", 64'(done_k > 0), 64'(1));
   endtask

   task automatic wait_beats(input int target, input int limit);
      int k = 0;
      while (beat_total < target && k < limit) begin
         @(negedge clk); #1;
         k++;
      end
      check("beats_reached", 64'(beat_total >= target), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int vw_k, done_k, base_b, base_r, base_d, base_s;
      rst_n = 1'b0; start = 1'b0; ram_full = 1'b0;
      cfg_in_cols = '0; cfg_chans_per_mem = '0; cfg_batch = '0;
      fork monitor_loop(); join_none

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rd_en", 64'(mem_rd_en), 64'(0));
      check("rst_addr", 64'(mem_addr), 64'(0));
      check("rst_data", 64'(data_in), 64'(0));
      check("rst_valid", 64'(valid_write), 64'(0));
      check("rst_feed", 64'(feed_start), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_cfg_err", 64'(cfg_err), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      @(posedge clk); #1; rst_n = 1'b1;

      // 4x4x2x1 = 32 beats, no backpressure
      base_b = beat_total; base_r = rd_total; base_d = done_total;
      launch(4, 2, 1);
      run_job(80, vw_k, done_k);
      check("t1_first_vw_cycle", 64'(vw_k), 64'(4));
      check("t1_done_cycle", 64'(done_k), 64'(36));
      check("t1_beats", 64'(beat_total - base_b), 64'(32));
      check("t1_reads", 64'(rd_total - base_r), 64'(32));
      check("t1_done_pulses", 64'(done_total - base_d), 64'(1));
      check("t1_queue_empty", 64'(exp_q.size()), 64'(0));
      @(negedge clk);
      check("t1_done_one_cycle", 64'(done), 64'(0));
      check("t1_busy_after", 64'(busy), 64'(0));

      // Five-cycle stall mid-stream
      base_b = beat_total; base_r = rd_total; base_d = done_total; base_s = stall_total;
      launch(4, 2, 1);
      wait_beats(base_b + 8, 60);
      @(posedge clk); #1; ram_full = 1'b1;
      repeat (5) @(posedge clk);
      #1; ram_full = 1'b0;
      run_job(80, vw_k, done_k);
      check("t2_beats", 64'(beat_total - base_b), 64'(32));
      check("t2_reads", 64'(rd_total - base_r), 64'(32));
      check("t2_stall_cycles", 64'(stall_total - base_s), 64'(5));
      check("t2_done_pulses", 64'(done_total - base_d), 64'(1));
      check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

      // Random backpressure, 3x3x3x1 = 27 beats
      base_b = beat_total; base_r = rd_total; base_d = done_total;
      launch(3, 3, 1);
      for (int k = 0; k < 400 && done_total == base_d; k++) begin
         @(posedge clk); #1;
         ram_full = ($urandom_range(0, 3) == 0);
      end
      ram_full = 1'b0;
      check("t3_done_pulses", 64'(done_total - base_d), 64'(1));
      check("t3_beats", 64'(beat_total - base_b), 64'(27));
      check("t3_reads", 64'(rd_total - base_r), 64'(27));
      check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

      // Empty job (batch = 0)
      base_b = beat_total; base_r = rd_total;
      launch(4, 2, 0);
      run_job(10, vw_k, done_k);
      check("t4_done_cycle", 64'(done_k), 64'(2));
      check("t4_no_valid", 64'(vw_k), 64'(-1));
      repeat (3) @(negedge clk);
      #1;
      check("t4_reads", 64'(rd_total - base_r), 64'(0));
      check("t4_beats", 64'(beat_total - base_b), 64'(0));

      // Oversize job: 256*256*2 > 2**16
      base_r = rd_total; base_d = done_total;
      launch(256, 2, 1);
      @(negedge clk);
      check("t5_busy_load", 64'(busy), 64'(1));
      @(negedge clk);
      check("t5_busy_low", 64'(busy), 64'(0));
      check("t5_cfg_err", 64'(cfg_err), 64'(1));
      repeat (4) @(negedge clk);
      #1;
      check("t5_cfg_err_sticky", 64'(cfg_err), 64'(1));
      check("t5_reads", 64'(rd_total - base_r), 64'(0));
      check("t5_no_done", 64'(done_total - base_d), 64'(0));

      // Reset at beat 10, then restart from address 0
      base_b = beat_total; base_d = done_total;
      launch(4, 2, 1);
      check("t6_cfg_err_cleared", 64'(cfg_err), 64'(0));
      wait_beats(base_b + 10, 60);
      @(posedge clk); #1; rst_n = 1'b0;
      #1;
      check("t6_rst_rd_en", 64'(mem_rd_en), 64'(0));
      check("t6_rst_addr", 64'(mem_addr), 64'(0));
      check("t6_rst_data", 64'(data_in), 64'(0));
      check("t6_rst_valid", 64'(valid_write), 64'(0));
      check("t6_rst_feed", 64'(feed_start), 64'(0));
      check("t6_rst_busy", 64'(busy), 64'(0));
      check("t6_rst_done", 64'(done), 64'(0));
      check("t6_rst_cfg_err", 64'(cfg_err), 64'(0));
      repeat (3) @(negedge clk);
      check("t6_rst_hold_valid", 64'(valid_write), 64'(0));
      check("t6_rst_hold_state", 64'(dbg_state), 64'(IDLE));
      @(posedge clk); #1; rst_n = 1'b1;
      check("t6_aborted_no_done", 64'(done_total - base_d), 64'(0));
      base_b = beat_total; base_r = rd_total; base_d = done_total;
      launch(4, 2, 1);
      run_job(80, vw_k, done_k);
      check("t6_restart_done_cycle", 64'(done_k), 64'(36));
      check("t6_restart_beats", 64'(beat_total - base_b), 64'(32));
      check("t6_restart_reads", 64'(rd_total - base_r), 64'(32));
      check("t6_queue_empty", 64'(exp_q.size()), 64'(0));

      // Start during RUN is ignored
      base_b = beat_total; base_r = rd_total; base_d = done_total;
      launch(4, 2, 1);
      wait_beats(base_b + 5, 60);
      @(posedge clk); #1;
      cfg_in_cols = AW'(8); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cfg_in_cols = AW'(4);
      run_job(80, vw_k, done_k);
      repeat (3) @(negedge clk);
      #1;
      check("t7_beats", 64'(beat_total - base_b), 64'(32));
      check("t7_reads", 64'(rd_total - base_r), 64'(32));
      check("t7_done_pulses", 64'(done_total - base_d), 64'(1));
      check("t7_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
